// File: rtl/apb_mem_ctrl.sv
// apb_mem_ctrl: APB completer that maps 32-bit lane accesses onto two wide
// single-port memories. Memory A is A_WORDS x A_WIDTH and memory B is
// B_WORDS x (B_LANES*32). Reads fetch the whole word and return one lane.
// Writes do a read-modify-write so that only the addressed lane changes.
// Optional feature: define APB_MEM_CTRL_LASTLINE_EN to add a one-entry
// last-line read cache. A read that hits the cache finishes without a
// memory access.
module apb_mem_ctrl #(
    parameter int A_WORDS = 19,
    parameter int B_WORDS = 21,
    parameter int A_WIDTH = 63,
    parameter int B_LANES = 3,
    localparam int BW     = 32 * B_LANES,
    localparam int AAW    = $clog2(A_WORDS),
    localparam int BAW    = $clog2(B_WORDS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               psel,
    input  logic               penable,
    input  logic               pwrite,
    input  logic [31:0]        paddr,
    input  logic [31:0]        pwdata,
    output logic [31:0]        prdata,
    output logic               pready,
    output logic               pslverr,
    output logic               a_cs,
    output logic               a_we,
    output logic [AAW-1:0]     a_addr,
    output logic [A_WIDTH-1:0] a_wdata,
    input  logic [A_WIDTH-1:0] a_rdata,
    output logic               b_cs,
    output logic               b_we,
    output logic [BAW-1:0]     b_addr,
    output logic [BW-1:0]      b_wdata,
    input  logic [BW-1:0]      b_rdata
);

    localparam int A_LANES = (A_WIDTH + 31) / 32;
    // Bits of the wide word register that physically exist in memory A
    localparam logic [BW-1:0] A_MASK = ~({BW{1'b1}} << A_WIDTH);

    typedef enum logic [2:0] {IDLE, REQ, CAP, WR, DONE} state_t;

    state_t           state_q;
    logic             tgt_q, wr_q;
    logic [1:0]       lane_q;
    logic [31:0]      wdat_q;
    logic [BW-1:0]    word_q;
    logic             a_cs_q, a_we_q, b_cs_q, b_we_q;
    logic [AAW-1:0]   a_addr_q;
    logic [BAW-1:0]   b_addr_q;
    logic [31:0]      prdata_q;
    logic             pready_q, pslverr_q;

    logic             req_tgt, req_err, hit;
    logic [5:0]       req_idx;
    logic [1:0]       req_lane;
    logic [31:0]      hit_data;
    logic [BW-1:0]    rd_word, wr_word;

    function automatic logic [31:0] lane_of(input logic [BW-1:0] w, input logic [1:0] l);
        return w[{l, 5'b0} +: 32];
    endfunction

    function automatic logic [BW-1:0] merge(input logic [BW-1:0] w, input logic [1:0] l,
                                            input logic [31:0] d);
        logic [BW-1:0] r;
        r = w;
        r[{l, 5'b0} +: 32] = d;
        return r;
    endfunction

    assign req_tgt  = paddr[12];
    assign req_idx  = paddr[9:4];
    assign req_lane = paddr[3:2];

    // Memory A is zero-extended so that both targets share one lane layout.
    // The A merge drops the bits above A_WIDTH, which removes pwdata[31] for lane 1.
    assign rd_word = tgt_q ? b_rdata : BW'(a_rdata);
    assign wr_word = merge(rd_word, lane_q, wdat_q) & (tgt_q ? {BW{1'b1}} : A_MASK);

    // Address legality: alignment, unused address bits, depth and lane range of the target
    always_comb begin
        req_err = (paddr[1:0] != 2'b0) || (paddr[31:13] != '0) || (paddr[11:10] != 2'b0);
        if (req_tgt)
            req_err = req_err || ({1'b0, req_idx} >= 7'(B_WORDS)) || ({1'b0, req_lane} >= 3'(B_LANES));
        else
            req_err = req_err || ({1'b0, req_idx} >= 7'(A_WORDS)) || ({1'b0, req_lane} >= 3'(A_LANES));
    end

`ifdef APB_MEM_CTRL_LASTLINE_EN
    logic          cache_vld_q, cache_tgt_q;
    logic [5:0]    cache_idx_q, idx_q;
    logic [BW-1:0] cache_word_q;

    assign hit      = cache_vld_q && !pwrite && (cache_tgt_q == req_tgt) && (cache_idx_q == req_idx);
    assign hit_data = lane_of(cache_word_q, req_lane);

    // Last-line cache: a read capture fills it, and a write-back to the cached word refreshes it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_vld_q  <= 1'b0;
            cache_tgt_q  <= 1'b0;
            cache_idx_q  <= '0;
            cache_word_q <= '0;
        end else if (state_q == CAP && !wr_q) begin
            cache_vld_q  <= 1'b1;
            cache_tgt_q  <= tgt_q;
            cache_idx_q  <= idx_q;
            cache_word_q <= rd_word;
        end else if (state_q == WR && cache_vld_q && cache_tgt_q == tgt_q && cache_idx_q == idx_q) begin
            cache_word_q <= word_q;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    // Sequencer: accept in IDLE, read in REQ/CAP, write back in WR if needed, respond in DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= 1'b0;
            wr_q      <= 1'b0;
            lane_q    <= '0;
            wdat_q    <= '0;
            word_q    <= '0;
            a_cs_q    <= 1'b0;
            a_we_q    <= 1'b0;
            b_cs_q    <= 1'b0;
            b_we_q    <= 1'b0;
            a_addr_q  <= '0;
            b_addr_q  <= '0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
`ifdef APB_MEM_CTRL_LASTLINE_EN
            idx_q     <= '0;
`endif
        end else begin
            a_cs_q    <= 1'b0;
            a_we_q    <= 1'b0;
            b_cs_q    <= 1'b0;
            b_we_q    <= 1'b0;
            prdata_q  <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            case (state_q)
                IDLE: if (psel && penable) begin
                    tgt_q  <= req_tgt;
                    lane_q <= req_lane;
                    wr_q   <= pwrite;
                    wdat_q <= pwdata;
`ifdef APB_MEM_CTRL_LASTLINE_EN
                    idx_q  <= req_idx;
`endif
                    if (req_err) begin
                        state_q   <= DONE;
                        pready_q  <= 1'b1;
                        pslverr_q <= 1'b1;
                    end else if (hit) begin
                        state_q  <= DONE;
                        pready_q <= 1'b1;
                        prdata_q <= hit_data;
                    end else begin
                        state_q <= REQ;
                        if (req_tgt) begin
                            b_cs_q   <= 1'b1;
                            b_addr_q <= req_idx[BAW-1:0];
                        end else begin
                            a_cs_q   <= 1'b1;
                            a_addr_q <= req_idx[AAW-1:0];
                        end
                    end
                end
                REQ: state_q <= CAP;
                CAP: begin
                    if (wr_q) begin
                        state_q <= WR;
                        word_q  <= wr_word;
                        a_cs_q  <= !tgt_q;
                        a_we_q  <= !tgt_q;
                        b_cs_q  <= tgt_q;
                        b_we_q  <= tgt_q;
                    end else begin
                        state_q  <= DONE;
                        word_q   <= rd_word;
                        pready_q <= 1'b1;
                        prdata_q <= lane_of(rd_word, lane_q);
                    end
                end
                WR: begin
                    state_q  <= DONE;
                    pready_q <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign a_cs    = a_cs_q;
    assign a_we    = a_we_q;
    assign a_addr  = a_addr_q;
    assign a_wdata = word_q[A_WIDTH-1:0];
    assign b_cs    = b_cs_q;
    assign b_we    = b_we_q;
    assign b_addr  = b_addr_q;
    assign b_wdata = word_q;
    assign prdata  = prdata_q;
    assign pready  = pready_q;
    assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_ctrl.sv
// Testbench for apb_mem_ctrl. It runs directed cases followed by random APB
// traffic. The expected results come from a word-array model of both memories.
// With APB_MEM_CTRL_LASTLINE_EN defined, the model also tracks the last-line cache.
module tb_apb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
    logic [31:0] paddr = '0, pwdata = '0;
    logic [31:0] prdata;
    logic        pready, pslverr;
    logic        a_cs, a_we, b_cs, b_we;
    logic [4:0]  a_addr, b_addr;
    logic [62:0] a_wdata;
    logic [62:0] a_rdata = '0;
    logic [95:0] b_wdata;
    logic [95:0] b_rdata = '0;

    apb_mem_ctrl dut (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
        .a_cs(a_cs), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata),
        .b_cs(b_cs), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    // Memory macros seen by the DUT, and the reference contents the bench predicts
    logic [62:0] memA [0:31];
    logic [95:0] memB [0:31];
    logic [62:0] refA [0:31];
    logic [95:0] refB [0:31];
    logic        pl_all = 1'b0;

    always @(posedge clk) begin
        if (pl_all)
            for (int i = 0; i < 32; i++) begin
                memA[i] <= refA[i];
                memB[i] <= refB[i];
            end
        if (a_cs && !a_we) a_rdata <= memA[a_addr];
        if (a_cs &&  a_we) memA[a_addr] <= a_wdata;
        if (b_cs && !b_we) b_rdata <= memB[b_addr];
        if (b_cs &&  b_we) memB[b_addr] <= b_wdata;
    end

    // Count the memory strobes and keep the last B write data
    int          acnt = 0, bcnt = 0, awe = 0, bwe = 0;
    logic [95:0] last_bw = '0;
    always @(posedge clk) begin
        if (a_cs) acnt <= acnt + 1;
        if (b_cs) bcnt <= bcnt + 1;
        if (a_we) awe  <= awe + 1;
        if (b_we) begin
            bwe     <= bwe + 1;
            last_bw <= b_wdata;
        end
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

`ifdef APB_MEM_CTRL_LASTLINE_EN
    bit cv = 1'b0, ct = 1'b0;
    int ci = 0;
`endif

    logic [31:0] x_rd;
    bit          x_err;
    int          x_lat;

    // One APB transfer: setup cycle, then C0 with penable, then wait for pready
    task automatic apb(input logic [31:0] addr, input bit wr, input logic [31:0] wd, input bit drop);
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = addr; pwrite = wr; pwdata = wd;
        @(negedge clk);
        penable = 1'b1;
        x_lat = 0; x_rd = '0; x_err = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (drop && n == 1) begin psel = 1'b0; penable = 1'b0; end
            if (pready) begin
                x_lat = n; x_rd = prdata; x_err = pslverr;
                break;
            end
        end
        if (x_lat == 0) x_lat = 99;
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic pl_pulse();
        @(negedge clk); pl_all = 1'b1;
        @(negedge clk); pl_all = 1'b0;
    endtask

    // Predict the transfer from the address rules, run it, check it, then update the model
    task automatic xfer(input string tag, input logic [31:0] addr, input bit wr,
                        input logic [31:0] wd, input bit drop);
        bit          tgt  = addr[12];
        int          idx  = int'(addr[9:4]);
        int          lane = int'(addr[3:2]);
        bit          err;
        logic [31:0] erd  = '0;
        int          elat;
        int          ea = 0, eb = 0;
        int          a0 = acnt, b0 = bcnt;
        err = (addr[1:0] != 0) || (addr[31:13] != 0) || (addr[11:10] != 0) ||
              (tgt ? (idx >= 21 || lane >= 3) : (idx >= 19 || lane >= 2));
        if (err) elat = 1;
        else if (wr) begin
            elat = 4;
            if (tgt) eb = 2; else ea = 2;
        end else begin
            elat = 3;
            if (tgt) begin eb = 1; erd = refB[idx][lane*32 +: 32]; end
            else begin
                ea  = 1;
                erd = (lane == 0) ? refA[idx][31:0] : {1'b0, refA[idx][62:32]};
            end
`ifdef APB_MEM_CTRL_LASTLINE_EN
            if (cv && ct == tgt && ci == idx) begin elat = 1; ea = 0; eb = 0; end
            else begin cv = 1'b1; ct = tgt; ci = idx; end
`endif
        end
        apb(addr, wr, wd, drop);
        if (!err && wr) begin
            if (tgt) refB[idx][lane*32 +: 32] = wd;
            else if (lane == 0) refA[idx][31:0] = wd;
            else refA[idx][62:32] = wd[30:0];
        end
        chk({tag, "/lat"}, x_lat, elat);
        chk({tag, "/err"}, x_err, err);
        chk({tag, "/rd"}, x_rd, erd);
        chk({tag, "/cs"}, {acnt - a0, bcnt - b0}, {ea, eb});
        if (!err && wr) begin
            if (tgt) chk({tag, "/memB"}, memB[idx], refB[idx]);
            else     chk({tag, "/memA"}, memA[idx], refA[idx]);
        end
    endtask

    initial begin
        logic [31:0] err_addr [5];
        int a0;
        err_addr = '{32'h0000_0130, 32'h0000_0008, 32'h0000_1150, 32'h0000_1002, 32'h0000_2000};

        for (int i = 0; i < 32; i++) begin
            refA[i] = 63'({$urandom(), $urandom()});
            refB[i] = {$urandom(), $urandom(), $urandom()};
        end
        pl_pulse();
        repeat (2) @(negedge clk);
        chk("reset", {prdata, pready, pslverr, a_cs, a_we, b_cs, b_we, a_addr, b_addr}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Lane 0 and lane 1 of memory A word 3
        xfer("wA3l0", 32'h0000_0030, 1'b1, 32'hDEAD_BEEF, 1'b0);
        xfer("wA3l1", 32'h0000_0034, 1'b1, 32'hFFFF_FFFF, 1'b0);
        chk("memA3", memA[3], 63'h7FFF_FFFF_DEAD_BEEF);
        xfer("rA3l0", 32'h0000_0030, 1'b0, 32'h0, 1'b0);
        chk("rA3l0/const", x_rd, 32'hDEAD_BEEF);
        xfer("rA3l1", 32'h0000_0034, 1'b0, 32'h0, 1'b0);
        chk("rA3l1/const", x_rd, 32'h7FFF_FFFF);

        // Memory B last word, top lane, over a known pattern
        refB[20] = 96'hAAAAAAAA_BBBBBBBB_CCCCCCCC;
        pl_pulse();
        xfer("wB20l2", 32'h0000_1148, 1'b1, 32'h1234_5678, 1'b0);
        chk("bwdata", last_bw, 96'h12345678_BBBBBBBB_CCCCCCCC);

        // Illegal addresses
        for (int i = 0; i < 5; i++) begin
            xfer($sformatf("err%0d", i), err_addr[i], i[0], 32'h5555_AAAA, 1'b0);
            chk($sformatf("err%0d/flag", i), x_err, 1'b1);
        end

        // psel dropped after acceptance: the transfer still completes
        xfer("drop", 32'h0000_0040, 1'b0, 32'h0, 1'b1);
        xfer("after_drop", 32'h0000_0044, 1'b0, 32'h0, 1'b0);

        // Reset during REQ: the chip select must fall immediately
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0060; pwrite = 1'b0;
        @(negedge clk); penable = 1'b1;
        @(negedge clk);
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        #1 chk("rst_req_cs", {a_cs, a_we, b_cs, b_we}, 4'b0);
        @(negedge clk); rst_n = 1'b1;
`ifdef APB_MEM_CTRL_LASTLINE_EN
        cv = 1'b0;
`endif

        // Reset during CAP of a write: nothing may be committed
        a0 = awe;
        @(negedge clk);
        psel = 1'b1; penable = 1'b0; paddr = 32'h0000_0070; pwrite = 1'b1; pwdata = 32'h5A5A_5A5A;
        @(negedge clk); penable = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0; psel = 1'b0; penable = 1'b0;
        #1 chk("rst_cap_ctl", {a_cs, a_we, b_cs, b_we}, 4'b0);
        @(negedge clk);
        chk("rst_cap_out", {pready, pslverr, prdata}, '0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cap_nowe", awe - a0, 0);
        chk("rst_cap_mem", memA[7], refA[7]);
`ifdef APB_MEM_CTRL_LASTLINE_EN
        cv = 1'b0;
`endif

        // Same line read twice, then written and read back
        xfer("rA5l0", 32'h0000_0050, 1'b0, 32'h0, 1'b0);
        xfer("rA5l1", 32'h0000_0054, 1'b0, 32'h0, 1'b0);
        xfer("wA5l1", 32'h0000_0054, 1'b1, 32'h0000_0001, 1'b0);
        xfer("rA5l1b", 32'h0000_0054, 1'b0, 32'h0, 1'b0);
        chk("rA5l1b/const", x_rd, 32'h0000_0001);

        // Random traffic, mostly on a few words so that lines get reused
        for (int i = 0; i < 40; i++) begin
            logic [31:0] ad;
            bit          t = 1'($urandom_range(0, 1));
            int          ix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 22))
                                                          : int'($urandom_range(0, 4));
            int          ln = int'($urandom_range(0, 3));
            ad = {19'b0, t, 6'b0, 6'(ix), 2'(ln), 2'b0};
            if ($urandom_range(0, 9) == 0) ad[1:0] = 2'b10;
            xfer($sformatf("rnd%0d", i), ad, 1'($urandom_range(0, 1)), $urandom(), 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
